hazard_ctrl: RTL and testbench

- Central hazard and stall sequencer for the 5-stage MIPS pipeline.
- Drives the hold, bubble and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus the EX-stage forwarding selects.
- Sequences load-use stalls, branch/jump flushes and multi-cycle data-memory waits (req/ack handshake).
- Keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 24 ++
 rtl/fwd_unit.sv | 16 +
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encodings, forward selects and the forwarding compare helper
package hazard_pkg;
    typedef enum logic [1:0] {S_RUN = 2'd0, S_LU = 2'd1, S_MWAIT = 2'd2} state_e;
    localparam logic [1:0] FW_REG = 2'b00;
    localparam logic [1:0] FW_MEM = 2'b10;
    localparam logic [1:0] FW_WB  = 2'b01;
    // The youngest producer (EX/MEM) wins over MEM/WB; $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic mem_we, input logic [4:0] mem_rd,
                                           input logic wb_we, input logic [4:0] wb_rd,
                                           input logic [4:0] src);
        return (mem_we && mem_rd != 5'd0 && mem_rd == src) ? FW_MEM :
               (wb_we && wb_rd != 5'd0 && wb_rd == src) ? FW_WB : FW_REG;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and stage-register control outputs
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs, id_rt, ex_rt, ex_rs_fw, ex_rt_fw, mem_Regadd, wb_Regadd;
    logic             id_uses_rt, ex_MemRead, mem_RegWrite, wb_RegWrite, mem_access;
    logic             branchCtrl, jumpCtrl, dmem_ack;
    logic             dmem_req, PCWrite, IFtoIDWrite, idex_bubble, exmem_hold, memwb_bubble, flush;
    logic [1:0]       fwdA, fwdB;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             timeout_err;
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, ex_rs_fw, ex_rt_fw,
               mem_RegWrite, mem_Regadd, wb_RegWrite, wb_Regadd, mem_access,
               branchCtrl, jumpCtrl, dmem_ack,
        input  dmem_req, PCWrite, IFtoIDWrite, idex_bubble, exmem_hold, memwb_bubble,
               flush, fwdA, fwdB, stall_cnt, flush_cnt, timeout_err
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, ex_rs_fw, ex_rt_fw,
               mem_RegWrite, mem_Regadd, wb_RegWrite, wb_Regadd, mem_access,
               branchCtrl, jumpCtrl, dmem_ack,
        output dmem_req, PCWrite, IFtoIDWrite, idex_bubble, exmem_hold, memwb_bubble,
               flush, fwdA, fwdB, stall_cnt, flush_cnt, timeout_err
    );
endinterface

// File: rtl/fwd_unit.sv
// fwd_unit: EX-stage operand forwarding selects from the EX/MEM and MEM/WB destinations
module fwd_unit
    import hazard_pkg::*;
(
    input  logic       mem_regwrite_i,
    input  logic [4:0] mem_regadd_i,
    input  logic       wb_regwrite_i,
    input  logic [4:0] wb_regadd_i,
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);
    assign fwd_a_o = fwd_sel(mem_regwrite_i, mem_regadd_i, wb_regwrite_i, wb_regadd_i, ex_rs_i);
    assign fwd_b_o = fwd_sel(mem_regwrite_i, mem_regadd_i, wb_regwrite_i, wb_regadd_i, ex_rt_i);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and data-memory-wait sequencer with forwarding and perf counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 7
) (
    input  logic            clk,
    input  logic            rst,
    hazard_ctrl_if.slave    hz
);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    state_e           state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic             pend_q, pend_d, err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d, fcnt_q, fcnt_d;
    logic             load_use, redirect, hold, ex_hold, mw_bub, idex_bub, fl, req;
    logic [1:0]       fwd_a, fwd_b;

    fwd_unit u_fwd (
        .mem_regwrite_i (hz.mem_RegWrite),
        .mem_regadd_i   (hz.mem_Regadd),
        .wb_regwrite_i  (hz.wb_RegWrite),
        .wb_regadd_i    (hz.wb_Regadd),
        .ex_rs_i        (hz.ex_rs_fw),
        .ex_rt_i        (hz.ex_rt_fw),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b)
    );

    assign load_use = hz.ex_MemRead && hz.ex_rt != 5'd0 &&
                      (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
    assign redirect = hz.branchCtrl || hz.jumpCtrl;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        pend_d   = pend_q;
        err_d    = err_q;
        req      = 1'b0;
        hold     = 1'b0;
        ex_hold  = 1'b0;
        mw_bub   = 1'b0;
        idex_bub = 1'b0;
        fl       = 1'b0;
        if (state_q == S_MWAIT) begin
            req = 1'b1;
            if (hz.dmem_ack) begin
                fl       = pend_q;
                idex_bub = pend_q;
                pend_d   = 1'b0;
                wait_d   = '0;
                state_d  = S_RUN;
            end else begin
                hold    = 1'b1;
                ex_hold = 1'b1;
                mw_bub  = 1'b1;
                wait_d  = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
                err_d   = err_q || wait_d == WAIT_MAX;
            end
        end else begin
            req     = hz.mem_access;
            state_d = S_RUN;
            // A redirect seen during a miss is replayed as a flush on the ack cycle.
            if (hz.mem_access && !hz.dmem_ack) begin
                hold    = 1'b1;
                ex_hold = 1'b1;
                mw_bub  = 1'b1;
                pend_d  = redirect;
                state_d = S_MWAIT;
            end else if (redirect) begin
                fl       = 1'b1;
                idex_bub = 1'b1;
            end else if (load_use && state_q == S_RUN) begin
                hold     = 1'b1;
                idex_bub = 1'b1;
                state_d  = S_LU;
            end
        end
        stall_d = stall_q + CNT_W'(hold && !(&stall_q));
        fcnt_d  = fcnt_q + CNT_W'(fl && !(&fcnt_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign hz.dmem_req     = !rst && req;
    assign hz.PCWrite      = !rst && hold;
    assign hz.IFtoIDWrite  = !rst && hold;
    assign hz.exmem_hold   = !rst && ex_hold;
    assign hz.idex_bubble  = rst || idex_bub;
    assign hz.memwb_bubble = rst || mw_bub;
    assign hz.flush        = rst || fl;
    assign hz.fwdA         = rst ? FW_REG : fwd_a;
    assign hz.fwdB         = rst ? FW_REG : fwd_b;
    assign hz.stall_cnt    = stall_q;
    assign hz.flush_cnt    = fcnt_q;
    assign hz.timeout_err  = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for the hazard sequencer
module tb_hazard_ctrl;
    typedef struct {
        string      tag;
        logic [10:0] ctl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) hz ();
    hazard_ctrl #(.CNT_W(16), .MAX_WAIT(64), .WAIT_W(7)) dut (.clk(clk), .rst(rst), .hz(hz));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // {dmem_req, PCWrite, IFtoIDWrite, idex_bubble, exmem_hold, memwb_bubble, flush, fwdA, fwdB}
    function automatic logic [10:0] mk(input logic rq, input logic pc, input logic ib, input logic eh,
                                       input logic mb, input logic fl, input logic [1:0] fa,
                                       input logic [1:0] fb);
        return {rq, pc, pc, ib, eh, mb, fl, fa, fb};
    endfunction

    function automatic logic [10:0] obs();
        return {hz.dmem_req, hz.PCWrite, hz.IFtoIDWrite, hz.idex_bubble, hz.exmem_hold,
                hz.memwb_bubble, hz.flush, hz.fwdA, hz.fwdB};
    endfunction

    task automatic step(input string tag, input logic [10:0] e);
        exp_t x;
        sb.push_back('{tag, e});
        @(negedge clk);
        x = sb.pop_front();
        chk(x.tag, 32'(obs()), 32'(x.ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rt = 0; hz.ex_MemRead = 0; hz.ex_rt = 0;
        hz.ex_rs_fw = 0; hz.ex_rt_fw = 0; hz.mem_RegWrite = 0; hz.mem_Regadd = 0;
        hz.wb_RegWrite = 0; hz.wb_Regadd = 0; hz.mem_access = 0; hz.branchCtrl = 0;
        hz.jumpCtrl = 0; hz.dmem_ack = 0;
    endtask

    localparam logic [10:0] IDLE = 11'd0;

    initial begin
        logic [10:0] frz, rst_o;
        frz   = mk(1, 1, 0, 1, 1, 0, 2'b00, 2'b00);
        rst_o = mk(0, 0, 1, 0, 1, 1, 2'b00, 2'b00);
        clr();
        hz.mem_access = 1;
        hz.ex_MemRead = 1; hz.ex_rt = 5; hz.id_rs = 5;
        step("rst0", rst_o);
        step("rst1", rst_o);
        chk("rst_stall", 32'(hz.stall_cnt), 0);
        chk("rst_flush", 32'(hz.flush_cnt), 0);
        chk("rst_err", 32'(hz.timeout_err), 0);
        rst = 0;
        clr();
        step("idle", IDLE);
        hz.ex_MemRead = 1; hz.ex_rt = 5; hz.id_rs = 5;
        step("lu_rs", mk(0, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        step("lu_rs_rel", IDLE);
        chk("lu_stall_cnt", 32'(hz.stall_cnt), 1);
        hz.id_rs = 3; hz.id_rt = 5; hz.id_uses_rt = 1;
        step("lu_rt", mk(0, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        step("lu_rt_rel", IDLE);
        hz.id_uses_rt = 0;
        step("no_rt_use", IDLE);
        hz.ex_rt = 0; hz.id_rs = 0;
        step("lu_r0", IDLE);
        chk("lu_stall_cnt2", 32'(hz.stall_cnt), 2);
        clr();
        hz.mem_RegWrite = 1; hz.wb_RegWrite = 1; hz.mem_Regadd = 8; hz.wb_Regadd = 8; hz.ex_rs_fw = 8;
        step("fwd_mem", mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00));
        hz.mem_Regadd = 0;
        step("fwd_wb", mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
        hz.wb_Regadd = 0; hz.ex_rs_fw = 0;
        step("fwd_r0", IDLE);
        hz.mem_Regadd = 8; hz.ex_rs_fw = 8; hz.wb_Regadd = 9; hz.ex_rt_fw = 9;
        step("fwd_ab", mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01));
        hz.mem_RegWrite = 0; hz.mem_Regadd = 9;
        step("fwd_nowe", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01));
        clr();
        hz.ex_MemRead = 1; hz.ex_rt = 5; hz.id_rs = 5; hz.branchCtrl = 1;
        step("br_over_lu", mk(0, 0, 1, 0, 0, 1, 2'b00, 2'b00));
        chk("br_flush_cnt", 32'(hz.flush_cnt), 1);
        chk("br_stall_cnt", 32'(hz.stall_cnt), 2);
        clr();
        hz.jumpCtrl = 1;
        step("jump", mk(0, 0, 1, 0, 0, 1, 2'b00, 2'b00));
        chk("jmp_flush_cnt", 32'(hz.flush_cnt), 2);
        clr();
        hz.mem_access = 1;
        for (int i = 0; i < 3; i++) step($sformatf("mw_frz%0d", i), frz);
        hz.dmem_ack = 1;
        step("mw_ack", mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        chk("mw_stall_cnt", 32'(hz.stall_cnt), 5);
        hz.branchCtrl = 1;
        step("hit_br", mk(1, 0, 1, 0, 0, 1, 2'b00, 2'b00));
        chk("hit_flush_cnt", 32'(hz.flush_cnt), 3);
        clr();
        hz.mem_access = 1; hz.jumpCtrl = 1;
        step("dj_frz0", frz);
        hz.jumpCtrl = 0;
        step("dj_frz1", frz);
        chk("dj_no_flush_yet", 32'(hz.flush_cnt), 3);
        hz.dmem_ack = 1;
        step("dj_ack", mk(1, 0, 1, 0, 0, 1, 2'b00, 2'b00));
        chk("dj_flush_cnt", 32'(hz.flush_cnt), 4);
        chk("dj_stall_cnt", 32'(hz.stall_cnt), 7);
        chk("short_wait_err", 32'(hz.timeout_err), 0);
        clr();
        hz.mem_access = 1;
        for (int i = 0; i < 70; i++) begin
            step($sformatf("to_frz%0d", i), frz);
            if (i == 63) chk("to_err_before", 32'(hz.timeout_err), 0);
            if (i == 64) chk("to_err_at", 32'(hz.timeout_err), 1);
        end
        hz.dmem_ack = 1;
        step("to_ack", mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        clr();
        step("to_idle", IDLE);
        chk("to_err_sticky", 32'(hz.timeout_err), 1);
        chk("to_stall_cnt", 32'(hz.stall_cnt), 77);
        hz.mem_access = 1;
        step("rw_frz0", frz);
        step("rw_frz1", frz);
        rst = 1;
        step("rw_rst", rst_o);
        rst = 0;
        clr();
        step("rw_idle", IDLE);
        chk("rw_stall", 32'(hz.stall_cnt), 0);
        chk("rw_flush", 32'(hz.flush_cnt), 0);
        chk("rw_err", 32'(hz.timeout_err), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
